// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state type.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] WSTRB_ALL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_RESP,
        RESPOND
    } state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master driven by a request/response command port.
// Optional feature: define AXI4_LITE_MASTER_WSTRB_EN to expose req_wstrb; otherwise writes use full strobes.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int addr_width = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [addr_width-1:0] req_addr,
    input  logic [31:0]           req_wdata,
`ifdef AXI4_LITE_MASTER_WSTRB_EN
    input  logic [3:0]            req_wstrb,
`endif

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [addr_width-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [addr_width-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    state_t                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [3:0]            req_strb;

`ifdef AXI4_LITE_MASTER_WSTRB_EN
    assign req_strb = req_wstrb;
`else
    assign req_strb = WSTRB_ALL;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                // req_ready comes up on the first edge after reset release
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_strb;
                    if (req_write) begin
                        state_d   = WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; never re-raised once accepted
                awvalid_d = awvalid_q && !m_axi_awready;
                wvalid_d  = wvalid_q && !m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d     = RESPOND;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_resp_d  = m_axi_bresp;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d   = RD_RESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_RESP: begin
                if (m_axi_rvalid) begin
                    state_d     = RESPOND;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with a small register-bank slave model (SLVERR at 0x7C).
module tb_axi4_lite_master;

    localparam int AW = 7;
`ifdef AXI4_LITE_MASTER_WSTRB_EN
    localparam logic [3:0] STRB_OR = 4'h0;
`else
    localparam logic [3:0] STRB_OR = 4'hF;
`endif

    logic          clk, rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]    m_axi_awprot, m_axi_arprot;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0]   m_axi_wdata, m_axi_rdata;
    logic [3:0]    m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    int errors = 0;
    int checks = 0;

    axi4_lite_master #(.addr_width(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef AXI4_LITE_MASTER_WSTRB_EN
        .req_wstrb(req_wstrb),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: acts on the falling edge so its outputs are settled for the next rising edge.
    logic [31:0]   mem [0:31];
    int            aw_stall = 0, ar_stall = 0, aw_cnt, ar_cnt;
    logic          aw_got, w_got, ar_got, b_fire, r_fire;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [31:0]   wr_data;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
            aw_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
            wr_addr = 0; rd_addr = 0; wr_data = 0;
        end else begin
            if (b_fire) begin m_axi_bvalid = 0; b_fire = 0; end
            if (r_fire) begin m_axi_rvalid = 0; r_fire = 0; end
            if (aw_got && w_got && !m_axi_bvalid) begin
                m_axi_bvalid = 1;
                m_axi_bresp  = (wr_addr == 7'h7C) ? 2'b10 : 2'b00;
                if (wr_addr != 7'h7C) mem[wr_addr[6:2]] = wr_data;
                aw_got = 0; w_got = 0;
            end
            if (ar_got && !m_axi_rvalid) begin
                m_axi_rvalid = 1; m_axi_rresp = 2'b00; m_axi_rdata = mem[rd_addr[6:2]];
                ar_got = 0;
            end
            if (m_axi_bvalid && m_axi_bready) b_fire = 1;
            if (m_axi_rvalid && m_axi_rready) r_fire = 1;
            if (m_axi_awvalid) begin
                m_axi_awready = (aw_cnt == aw_stall);
                if (m_axi_awready) begin aw_got = 1; wr_addr = m_axi_awaddr; end
                aw_cnt++;
            end else begin
                m_axi_awready = 0; aw_cnt = 0;
            end
            m_axi_wready = m_axi_wvalid;
            if (m_axi_wvalid) begin w_got = 1; wr_data = m_axi_wdata; end
            if (m_axi_arvalid) begin
                m_axi_arready = (ar_cnt == ar_stall);
                if (m_axi_arready) begin ar_got = 1; rd_addr = m_axi_araddr; end
                ar_cnt++;
            end else begin
                m_axi_arready = 0; ar_cnt = 0;
            end
        end
    end

    // Returns at #1 after the accept edge T.
    task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic ok);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        ok = (req_ready === 1'b1);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    // Edges after the accept edge until rsp_valid is seen; -1 on timeout.
    task automatic wait_rsp(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic rsp_handshake();
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        req_wstrb = 4'hF; rsp_ready = 0;
        #2;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_valids: got %b want 000000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid});
        end
        checks++;
        if ({rsp_write, rsp_resp, rsp_rdata, m_axi_awaddr, m_axi_wdata, m_axi_wstrb} !== '0) begin
            errors++; $display("FAIL reset_data: rsp_rdata=%h awaddr=%h wdata=%h wstrb=%h want all 0",
                rsp_rdata, m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
        end
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        logic ok;
        send_req(1'b1, 7'h04, 32'hDEADBEEF, 4'hF, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_accept: got %b want 1", ok); end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid} !== 3'b110) begin
            errors++; $display("FAIL wr_valids_T1: got %b want 110", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid});
        end
        checks++;
        if ({m_axi_awaddr, m_axi_wdata, m_axi_awprot} !== {7'h04, 32'hDEADBEEF, 3'b000}) begin
            errors++; $display("FAIL wr_addr_data: got %h/%h/%b want 04/deadbeef/000", m_axi_awaddr, m_axi_wdata, m_axi_awprot);
        end
        checks++;
        if (m_axi_wstrb !== (req_wstrb | STRB_OR)) begin
            errors++; $display("FAIL wr_full_strb: got %h want f", m_axi_wstrb);
        end
        @(posedge clk); #1;
        checks++;
        if ({m_axi_bready, m_axi_awvalid, rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL wr_bready_T2: got %b want 100", {m_axi_bready, m_axi_awvalid, rsp_valid});
        end
        @(posedge clk); #1;
        // value now held is what the consumer samples at accept+3
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_T3: got %b want 1", rsp_valid); end
        checks++;
        if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b1, 2'b00, 32'h0}) begin
            errors++; $display("FAIL wr_rsp_fields: got w=%b resp=%b rdata=%h want 1/00/0", rsp_write, rsp_resp, rsp_rdata);
        end
        rsp_handshake();
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL wr_ready_return: got %b want 01", {rsp_valid, req_ready});
        end

        send_req(1'b0, 7'h04, 32'h0, 4'hF, ok);
        checks++;
        if ({ok, m_axi_arvalid, m_axi_awvalid, m_axi_araddr, m_axi_arprot} !== {1'b1, 1'b1, 1'b0, 7'h04, 3'b000}) begin
            errors++; $display("FAIL rd_ar_T1: got ok=%b arv=%b awv=%b araddr=%h want 1/1/0/04",
                ok, m_axi_arvalid, m_axi_awvalid, m_axi_araddr);
        end
        @(posedge clk); #1;
        checks++;
        if ({m_axi_rready, m_axi_arvalid} !== 2'b10) begin
            errors++; $display("FAIL rd_rready_T2: got %b want 10", {m_axi_rready, m_axi_arvalid});
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata} !== {1'b1, 1'b0, 2'b00, 32'hDEADBEEF}) begin
            errors++; $display("FAIL rd_rsp_T3: got v=%b w=%b resp=%b rdata=%h want 1/0/00/deadbeef",
                rsp_valid, rsp_write, rsp_resp, rsp_rdata);
        end
        rsp_handshake();
    endtask

    task automatic test_aw_stall();
        logic ok;
        int aw_hi = 0, w_hi = 0, early = 0, bad_addr = 0, done = 0;
        aw_stall = 3;
        send_req(1'b1, 7'h10, 32'h12345678, 4'hF, ok);
        for (int i = 0; i < 30; i++) begin
            if (m_axi_awvalid === 1'b1) aw_hi++;
            if (m_axi_wvalid === 1'b1) w_hi++;
            if (m_axi_bready === 1'b1 && m_axi_awvalid === 1'b1) early++;
            if (m_axi_awvalid === 1'b1 && m_axi_awaddr !== 7'h10) bad_addr++;
            if (rsp_valid === 1'b1) begin done = 1; break; end
            @(posedge clk); #1;
        end
        aw_stall = 0;
        checks++; if (w_hi != 1) begin errors++; $display("FAIL stall_wvalid_cycles: got %0d want 1", w_hi); end
        checks++; if (aw_hi != 4) begin errors++; $display("FAIL stall_awvalid_cycles: got %0d want 4", aw_hi); end
        checks++; if (early != 0) begin errors++; $display("FAIL stall_bready_early: got %0d want 0", early); end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL stall_awaddr_stable: got %0d want 0", bad_addr); end
        checks++;
        if ({done[0], rsp_write, rsp_resp} !== 4'b1100) begin
            errors++; $display("FAIL stall_rsp: got done=%0d w=%b resp=%b want 1/1/00", done, rsp_write, rsp_resp);
        end
        rsp_handshake();
    endtask

    task automatic test_slverr();
        logic ok;
        int n;
        send_req(1'b1, 7'h7C, 32'hCAFE0001, 4'hF, ok);
        wait_rsp(n);
        checks++; if (n != 2) begin errors++; $display("FAIL slverr_latency: got %0d want 2", n); end
        checks++;
        if ({rsp_write, rsp_resp, rsp_rdata} !== {1'b1, 2'b10, 32'h0}) begin
            errors++; $display("FAIL slverr_rsp: got w=%b resp=%b rdata=%h want 1/10/0", rsp_write, rsp_resp, rsp_rdata);
        end
        rsp_handshake();
    endtask

    task automatic test_wstrb();
        logic ok;
        int n;
        send_req(1'b1, 7'h08, 32'h0000ABCD, 4'b0011, ok);
        checks++;
        if (m_axi_wstrb !== (req_wstrb | STRB_OR)) begin
            errors++; $display("FAIL wstrb_drive: got %b want %b", m_axi_wstrb, req_wstrb | STRB_OR);
        end
        wait_rsp(n);
        checks++; if (n != 2) begin errors++; $display("FAIL wstrb_latency: got %0d want 2", n); end
        rsp_handshake();
    endtask

    task automatic test_backpressure();
        logic ok;
        int n;
        send_req(1'b0, 7'h04, 32'h0, 4'hF, ok);
        wait_rsp(n);
        checks++; if (n != 2) begin errors++; $display("FAIL bp_latency: got %0d want 2", n); end
        req_valid = 1; req_write = 1; req_addr = 7'h20; req_wdata = 32'h55AA55AA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata, req_ready, m_axi_awvalid} !==
                {1'b1, 1'b0, 2'b00, 32'hDEADBEEF, 1'b0, 1'b0}) begin
                errors++; $display("FAIL bp_hold_%0d: got v=%b w=%b resp=%b rdata=%h rdy=%b awv=%b want 1/0/00/deadbeef/0/0",
                    i, rsp_valid, rsp_write, rsp_resp, rsp_rdata, req_ready, m_axi_awvalid);
            end
        end
        req_valid = 0;
        rsp_handshake();
        checks++;
        if ({rsp_valid, req_ready, m_axi_awvalid} !== 3'b010) begin
            errors++; $display("FAIL bp_release: got %b want 010", {rsp_valid, req_ready, m_axi_awvalid});
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        int seen = 0;
        ar_stall = 1000;
        send_req(1'b0, 7'h0C, 32'h0, 4'hF, ok);
        checks++; if (m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_arvalid_before: got %b want 1", m_axi_arvalid); end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({m_axi_arvalid, m_axi_rready, req_ready, rsp_valid} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_drop: got %b want 0000", {m_axi_arvalid, m_axi_rready, req_ready, rsp_valid});
        end
        @(posedge clk); @(posedge clk); #3;
        ar_stall = 0;
        rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, m_axi_arvalid} !== 2'b10) begin
            errors++; $display("FAIL rst_mid_release: got %b want 10", {req_ready, m_axi_arvalid});
        end
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_aw_stall();
        test_slverr();
        test_wstrb();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
